line_buffer_scaler: RTL and testbench



---
 rtl/line_buffer_scaler.sv | 140 ++++++++++++++
 tb/tb_line_buffer_scaler.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/line_buffer_scaler.sv
// Double-buffered playfield line store, replayed 4x/2x into the output raster.
// Define SCANLINE_EFFECT_EN to dim the luma of the last replicated row in each group.
module line_buffer_scaler #(
    parameter int         LINE_PIXELS  = 160,
    parameter int         LINES        = 192,
    parameter int         H_SCALE      = 4,
    parameter int         V_SCALE      = 2,
    parameter int         X_START      = 40,
    parameter int         Y_START      = 48,
    parameter logic [6:0] BORDER_COLOR = 7'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_valid,
    input  logic [6:0]  wr_color,
    input  logic        wr_last,
    output logic        wr_ready,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    output logic [6:0]  color,
    output logic [15:0] underflow_count,
    output logic        overrun
);
    localparam int         H_SH   = $clog2(H_SCALE);
    localparam logic [9:0] X_LO   = 10'(X_START);
    localparam logic [9:0] X_HI   = 10'(X_START + LINE_PIXELS * H_SCALE);
    localparam logic [9:0] Y_LO   = 10'(Y_START);
    localparam logic [9:0] Y_HI   = 10'(Y_START + LINES * V_SCALE);
    localparam logic [9:0] V_MASK = 10'(V_SCALE - 1);
    localparam logic [7:0] LP     = 8'(LINE_PIXELS);

    logic [6:0] mem [0:1][0:LINE_PIXELS-1];
    logic [1:0] full;
    logic       wr_bank;
    logic [7:0] wr_addr;
    logic       rd_bank;
    logic       rd_hold;

    logic       accept, in_range;
    logic       vwin, hwin, group_start;
    logic [9:0] vrow, hoff;
    logic [7:0] rd_idx;
    logic [6:0] rd_px, pix_out;
    logic [1:0] set_mask, clr_mask;
    logic       hold_set, advance, underflow;

    assign wr_ready = !full[wr_bank];

    always_comb begin
        accept      = wr_valid && wr_ready;
        in_range    = wr_addr < LP;
        vwin        = (vpos >= Y_LO) && (vpos < Y_HI);
        hwin        = (hpos >= X_LO) && (hpos < X_HI);
        vrow        = vpos - Y_LO;
        hoff        = hpos - X_LO;
        rd_idx      = 8'(hoff >> H_SH);
        group_start = (hpos == 10'd0) && vwin && ((vrow & V_MASK) == 10'd0);
    end

    // Writer only ever sets a non-full flag and the reader only clears a held
    // (full) one, so the two masks never touch the same bank.
    always_comb begin
        set_mask  = 2'b00;
        clr_mask  = 2'b00;
        hold_set  = 1'b0;
        advance   = 1'b0;
        underflow = 1'b0;
        if (accept && wr_last)
            set_mask[wr_bank] = 1'b1;
        if (group_start) begin
            if (!rd_hold) begin
                if (full[rd_bank]) hold_set  = 1'b1;
                else               underflow = 1'b1;
            end else begin
                if (full[~rd_bank]) begin
                    advance           = 1'b1;
                    clr_mask[rd_bank] = 1'b1;
                end else begin
                    underflow = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_px = mem[rd_bank][rd_idx];
    end

`ifdef SCANLINE_EFFECT_EN
    logic       last_row;
    logic [2:0] luma;
    always_comb begin
        last_row = (vrow & V_MASK) == V_MASK;
        luma     = (rd_px[2:0] >= 3'd2) ? rd_px[2:0] - 3'd2 : 3'd0;
        pix_out  = last_row ? {rd_px[6:3], luma} : rd_px;
    end
`else
    always_comb begin
        pix_out = rd_px;
    end
`endif

    // Line RAM is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (accept && in_range)
            mem[wr_bank][wr_addr] <= wr_color;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full            <= 2'b00;
            wr_bank         <= 1'b0;
            wr_addr         <= 8'd0;
            rd_bank         <= 1'b0;
            rd_hold         <= 1'b0;
            color           <= BORDER_COLOR;
            underflow_count <= 16'd0;
            overrun         <= 1'b0;
        end else begin
            full <= (full | set_mask) & ~clr_mask;
            if (accept) begin
                if (!in_range)
                    overrun <= 1'b1;
                if (wr_last) begin
                    wr_bank <= ~wr_bank;
                    wr_addr <= 8'd0;
                end else if (in_range) begin
                    wr_addr <= wr_addr + 8'd1;
                end
            end
            if (hold_set)
                rd_hold <= 1'b1;
            if (advance)
                rd_bank <= ~rd_bank;
            if (underflow && underflow_count != 16'hFFFF)
                underflow_count <= underflow_count + 16'd1;
            color <= (vwin && hwin && rd_hold) ? pix_out : BORDER_COLOR;
        end
    end
endmodule

// File: tb/tb_line_buffer_scaler.sv
// Directed bench for line_buffer_scaler: reset, replay scaling, bank hand-off, underflow, overrun.
module tb_line_buffer_scaler;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [6:0]  wr_color = 7'd0;
    logic        wr_last = 1'b0;
    logic        wr_ready;
    logic [9:0]  hpos = 10'd700;
    logic [9:0]  vpos = 10'd0;
    logic [6:0]  color;
    logic [15:0] underflow_count;
    logic        overrun;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    line_buffer_scaler dut (
        .clk(clk), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_color(wr_color), .wr_last(wr_last), .wr_ready(wr_ready),
        .hpos(hpos), .vpos(vpos), .color(color),
        .underflow_count(underflow_count), .overrun(overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic px(input logic [6:0] c, input logic last);
        wr_valid = 1'b1;
        wr_color = c;
        wr_last  = last;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic line(input int n, input int off);
        for (int i = 0; i < n; i++)
            px(7'((i + off) & 127), i == n - 1);
    endtask

    task automatic rast(input int v, input int h);
        vpos = 10'(v);
        hpos = 10'(h);
        tick();
        hpos = 10'd700;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
    endtask

    // Last row of a group is dimmed when the scanline option is built in.
    function automatic logic [6:0] dim(input logic [6:0] c);
`ifdef SCANLINE_EFFECT_EN
        return {c[6:3], (c[2:0] >= 3'd2) ? c[2:0] - 3'd2 : 3'd0};
`else
        return c;
`endif
    endfunction

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_color", 16'(color), 16'h0);
        chk("rst_ready", 16'(wr_ready), 16'h1);
        chk("rst_uf", underflow_count, 16'h0);
        chk("rst_overrun", 16'(overrun), 16'h0);
        reset_n = 1'b1;
        tick();

        // One full line, replay on rows 48/49
        line(160, 0);
        chk("ready_after_line", 16'(wr_ready), 16'h1);
        rast(48, 0);
        chk("uf_first_group", underflow_count, 16'h0);
        rast(48, 40);  chk("px_h40", 16'(color), 16'h0);
        rast(48, 43);  chk("px_h43", 16'(color), 16'h0);
        rast(48, 44);  chk("px_h44", 16'(color), 16'h1);
        rast(48, 679); chk("px_h679", 16'(color), 16'h1F);
        rast(48, 680); chk("px_h680", 16'(color), 16'h0);
        rast(48, 39);  chk("px_h39", 16'(color), 16'h0);
        rast(49, 0);
        rast(49, 44);  chk("row49_h44", 16'(color), 16'(dim(7'h01)));
        rast(49, 679); chk("row49_h679", 16'(color), 16'(dim(7'h1F)));

        // No new line for the next group: underflow, line repeats
        rast(50, 0);   chk("uf_repeat", underflow_count, 16'h1);
        rast(50, 44);  chk("repeat_h44", 16'(color), 16'h1);
        rast(51, 0);   chk("uf_odd_row", underflow_count, 16'h1);
        rast(52, 0);   chk("uf_next_group", underflow_count, 16'h2);

        // No writes at all: border output, one underflow per group
        do_reset();
        chk("rst2_uf", underflow_count, 16'h0);
        rast(48, 0);  chk("nw_uf48", underflow_count, 16'h1);
        rast(48, 44); chk("nw_border48", 16'(color), 16'h0);
        rast(49, 0);  chk("nw_uf49", underflow_count, 16'h1);
        rast(50, 0);  chk("nw_uf50", underflow_count, 16'h2);
        rast(50, 44); chk("nw_border50", 16'(color), 16'h0);
        rast(51, 0);  chk("nw_uf51", underflow_count, 16'h2);

        // Two lines with no reader: writer stalls until the reader advances
        do_reset();
        line(160, 0);
        line(160, 5);
        chk("both_full_ready", 16'(wr_ready), 16'h0);
        wr_valid = 1'b1; wr_color = 7'h7F; wr_last = 1'b1;
        tick(); tick();
        wr_valid = 1'b0; wr_last = 1'b0;
        chk("stalled_ready", 16'(wr_ready), 16'h0);
        chk("stalled_overrun", 16'(overrun), 16'h0);
        rast(48, 0);  chk("hold_ready", 16'(wr_ready), 16'h0);
        rast(48, 44); chk("bank0_h44", 16'(color), 16'h1);
        rast(50, 0);  chk("advance_ready", 16'(wr_ready), 16'h1);
        chk("advance_uf", underflow_count, 16'h0);
        rast(50, 40); chk("bank1_h40", 16'(color), 16'h5);
        rast(50, 44); chk("bank1_h44", 16'(color), 16'h6);

        // Overlong line: excess pixels dropped, overrun sticky
        do_reset();
        for (int i = 0; i < 170; i++)
            px((i < 160) ? 7'((i + 9) & 127) : 7'h7F, i == 169);
        chk("ovr_flag", 16'(overrun), 16'h1);
        chk("ovr_ready", 16'(wr_ready), 16'h1);
        rast(48, 0);
        rast(48, 40);  chk("ovr_h40", 16'(color), 16'h9);
        rast(48, 44);  chk("ovr_h44", 16'(color), 16'hA);
        rast(48, 679); chk("ovr_h679", 16'(color), 16'h28);

        // Reset in the middle of a line abandons it
        do_reset();
        for (int i = 0; i < 80; i++)
            px(7'h3F, 1'b0);
        reset_n = 1'b0;
        #2;
        chk("mid_rst_ready", 16'(wr_ready), 16'h1);
        chk("mid_rst_overrun", 16'(overrun), 16'h0);
        chk("mid_rst_color", 16'(color), 16'h0);
        reset_n = 1'b1;
        tick();
        line(160, 'h15);
        rast(48, 0);
        rast(48, 40); chk("after_rst_h40", 16'(color), 16'h15);
        rast(48, 44); chk("after_rst_h44", 16'(color), 16'h16);
        rast(49, 0);
        rast(49, 40); chk("after_rst_r49_h40", 16'(color), 16'(dim(7'h15)));
        rast(49, 44); chk("after_rst_r49_h44", 16'(color), 16'(dim(7'h16)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
